// File: rtl/exception_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exception_pkg
// Description : Shared cause bit layout, exception codes, vector constants
//               and state encoding for the multi-issue exception resolver.
// Revision    : 1.0 - initial release
// ============================================================================
package exception_pkg;

  // Cause vector layout; a lower index means a higher priority.
  localparam int NUM_CAUSES    = 13;
  localparam int CAUSE_ADEL_IF = 0;
  localparam int CAUSE_TLBR_IF = 1;
  localparam int CAUSE_TLBI_IF = 2;
  localparam int CAUSE_CPU     = 3;
  localparam int CAUSE_RI      = 4;
  localparam int CAUSE_OV      = 5;
  localparam int CAUSE_BP      = 6;
  localparam int CAUSE_SYS     = 7;
  localparam int CAUSE_ADEL_D  = 8;
  localparam int CAUSE_ADES_D  = 9;
  localparam int CAUSE_TLBR_D  = 10;
  localparam int CAUSE_TLBI_D  = 11;
  localparam int CAUSE_MOD     = 12;

  typedef logic [4:0] exc_code_t;

  localparam exc_code_t CODE_INT  = 5'h00;
  localparam exc_code_t CODE_MOD  = 5'h01;
  localparam exc_code_t CODE_TLBL = 5'h02;
  localparam exc_code_t CODE_TLBS = 5'h03;
  localparam exc_code_t CODE_ADEL = 5'h04;
  localparam exc_code_t CODE_ADES = 5'h05;
  localparam exc_code_t CODE_SYS  = 5'h08;
  localparam exc_code_t CODE_BP   = 5'h09;
  localparam exc_code_t CODE_RI   = 5'h0A;
  localparam exc_code_t CODE_CPU  = 5'h0B;
  localparam exc_code_t CODE_OV   = 5'h0C;

  localparam logic [31:0] EXC_BASE_BEV0  = 32'h8000_0000;
  localparam logic [31:0] EXC_BASE_BEV1  = 32'hBFC0_0200;
  localparam logic [31:0] OFFSET_REFILL  = 32'h0000_0000;
  localparam logic [31:0] OFFSET_GENERAL = 32'h0000_0180;
  localparam logic [31:0] OFFSET_INT     = 32'h0000_0200;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  // ExcCode for a single cause bit; data-side TLB misses split on access type.
  function automatic exc_code_t cause_code(input int idx, input logic is_store);
    case (idx)
      CAUSE_ADEL_IF, CAUSE_ADEL_D:  return CODE_ADEL;
      CAUSE_TLBR_IF, CAUSE_TLBI_IF: return CODE_TLBL;
      CAUSE_CPU:                    return CODE_CPU;
      CAUSE_RI:                     return CODE_RI;
      CAUSE_OV:                     return CODE_OV;
      CAUSE_BP:                     return CODE_BP;
      CAUSE_SYS:                    return CODE_SYS;
      CAUSE_ADES_D:                 return CODE_ADES;
      CAUSE_TLBR_D, CAUSE_TLBI_D:   return is_store ? CODE_TLBS : CODE_TLBL;
      CAUSE_MOD:                    return CODE_MOD;
      default:                      return CODE_INT;
    endcase
  endfunction

  // Address errors and every TLB fault report the faulting address.
  function automatic logic cause_sets_badv(input int idx);
    case (idx)
      CAUSE_ADEL_IF, CAUSE_TLBR_IF, CAUSE_TLBI_IF,
      CAUSE_ADEL_D,  CAUSE_ADES_D,
      CAUSE_TLBR_D,  CAUSE_TLBI_D,  CAUSE_MOD: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/exception_unit_mi_lane_decode.sv
`default_nettype none
// ============================================================================
// Module      : exc_lane_decode
// Description : Resolves one commit lane's cause vector to its highest
//               priority exception: code, refill flag and BadVAddr enable.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_lane_decode
  import exception_pkg::*;
(
  input  logic                  i_valid,
  input  logic [NUM_CAUSES-1:0] i_cause,
  input  logic                  i_is_store,
  output logic                  o_exc,
  output exc_code_t             o_code,
  output logic                  o_refill,
  output logic                  o_badv_we
);

  assign o_exc = i_valid & (|i_cause);

  // Scan from the lowest priority upward so the lowest set bit wins.
  always_comb begin
    o_code    = CODE_INT;
    o_refill  = 1'b0;
    o_badv_we = 1'b0;
    for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
      if (i_cause[i]) begin
        o_code    = cause_code(i, i_is_store);
        o_refill  = (i == CAUSE_TLBR_IF) || (i == CAUSE_TLBR_D);
        o_badv_we = cause_sets_badv(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/exception_unit_mi.sv
`default_nettype none
// ============================================================================
// Module      : exception_unit_mi
// Description : Multi-issue exception resolver. Picks the oldest excepting
//               (or ERET) lane, pulses flush/CP0 update, then holds a
//               registered fetch redirect until it is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module exception_unit_mi
  import exception_pkg::*;
#(
  parameter int ISSUE_WIDTH = 2,
  parameter int NUM_HW_INT  = 6,   // at most 6 (Cause.IP[7:2])
  parameter int SYNC_INT    = 1
)(
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [ISSUE_WIDTH-1:0]           lane_valid,
  input  logic [ISSUE_WIDTH*NUM_CAUSES-1:0] lane_cause,
  input  logic [ISSUE_WIDTH*32-1:0]        lane_pc,
  input  logic [ISSUE_WIDTH-1:0]           lane_bd,
  input  logic [ISSUE_WIDTH*32-1:0]        lane_badvaddr,
  input  logic [ISSUE_WIDTH-1:0]           lane_is_store,
  input  logic [ISSUE_WIDTH-1:0]           lane_is_eret,
  input  logic [NUM_HW_INT-1:0]            hw_int,
  input  logic                             cp0_ie,
  input  logic                             cp0_exl,
  input  logic                             cp0_erl,
  input  logic                             cp0_bev,
  input  logic                             cause_iv,
  input  logic [7:0]                       cp0_im,
  input  logic [1:0]                       cause_ip_sw,
  input  logic [31:0]                      cp0_epc,
  output logic [7:0]                       ip_pending,
  output logic [ISSUE_WIDTH-1:0]           commit_mask,
  output logic                             flush,
  output logic                             stall,
  output logic                             exc_we,
  output logic [4:0]                       exc_code,
  output logic [31:0]                      exc_epc,
  output logic                             exc_bd,
  output logic                             exc_badvaddr_we,
  output logic [31:0]                      exc_badvaddr,
  output logic                             eret_we,
  output logic                             redirect_valid,
  output logic [31:0]                      redirect_pc,
  input  logic                             redirect_ready
);

  state_t                 r_state;
  logic                   r_redirect_valid;
  logic [31:0]            r_redirect_pc;

  logic [NUM_HW_INT-1:0]  w_hw_sync;
  logic [5:0]             w_hw_ext;
  logic                   w_int_req;

  logic                   w_exc     [ISSUE_WIDTH];
  exc_code_t              w_code    [ISSUE_WIDTH];
  logic                   w_refill  [ISSUE_WIDTH];
  logic                   w_badv_we [ISSUE_WIDTH];

  logic                   w_hit;
  logic                   w_sel_exc;
  logic                   w_sel_eret;
  exc_code_t              w_sel_code;
  logic                   w_sel_refill;
  logic                   w_sel_badv_we;
  logic                   w_sel_bd;
  logic [31:0]            w_sel_pc;
  logic [31:0]            w_sel_badv;
  logic [ISSUE_WIDTH-1:0] w_keep;
  logic [31:0]            w_base;
  logic [31:0]            w_offset;
  logic [31:0]            w_target;
  logic                   w_active;

  generate
    if (SYNC_INT != 0) begin : g_sync
      logic [NUM_HW_INT-1:0] r_meta;
      logic [NUM_HW_INT-1:0] r_sync;
      // Two-flop synchronizer for the asynchronous interrupt levels.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          r_meta <= '0;
          r_sync <= '0;
        end else begin
          r_meta <= hw_int;
          r_sync <= r_meta;
        end
      end
      assign w_hw_sync = r_sync;
    end else begin : g_nosync
      assign w_hw_sync = hw_int;
    end
  endgenerate

  // Map hardware lines onto IP[7:2], unused upper lines read as zero.
  always_comb begin
    w_hw_ext                 = '0;
    w_hw_ext[NUM_HW_INT-1:0] = w_hw_sync;
  end

  assign ip_pending = {w_hw_ext, cause_ip_sw};
  assign w_int_req  = (|(ip_pending & cp0_im)) & cp0_ie & ~cp0_exl & ~cp0_erl;

  generate
    for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_lane
      exc_lane_decode u_dec (
        .i_valid    (lane_valid[k]),
        .i_cause    (lane_cause[k*NUM_CAUSES +: NUM_CAUSES]),
        .i_is_store (lane_is_store[k]),
        .o_exc      (w_exc[k]),
        .o_code     (w_code[k]),
        .o_refill   (w_refill[k]),
        .o_badv_we  (w_badv_we[k])
      );
    end
  endgenerate

  // Oldest event lane wins. A pending interrupt makes the lowest valid lane
  // an event; any older lane is invalid, so the same scan covers it.
  always_comb begin
    w_hit         = 1'b0;
    w_sel_exc     = 1'b0;
    w_sel_eret    = 1'b0;
    w_sel_code    = CODE_INT;
    w_sel_refill  = 1'b0;
    w_sel_badv_we = 1'b0;
    w_sel_bd      = 1'b0;
    w_sel_pc      = '0;
    w_sel_badv    = '0;
    w_keep        = '0;
    for (int k = ISSUE_WIDTH - 1; k >= 0; k--) begin
      if (lane_valid[k] && (w_exc[k] || lane_is_eret[k] || w_int_req)) begin
        w_hit         = 1'b1;
        w_sel_exc     = w_int_req || w_exc[k];
        w_sel_eret    = !w_int_req && !w_exc[k];
        w_sel_code    = w_int_req ? CODE_INT : w_code[k];
        w_sel_refill  = !w_int_req && w_refill[k];
        w_sel_badv_we = !w_int_req && w_badv_we[k];
        w_sel_bd      = lane_bd[k];
        w_sel_pc      = lane_pc[k*32 +: 32];
        // Instruction-fetch causes occupy the top three priorities.
        w_sel_badv    = (|lane_cause[k*NUM_CAUSES +: 3]) ? lane_pc[k*32 +: 32]
                                                         : lane_badvaddr[k*32 +: 32];
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
          w_keep[j] = lane_valid[j] && (j < k);
        end
      end
    end
  end

  // Exception vector, or the saved EPC for ERET.
  always_comb begin
    w_base = cp0_bev ? EXC_BASE_BEV1 : EXC_BASE_BEV0;
    if ((w_sel_code == CODE_INT) && w_sel_exc && cause_iv) begin
      w_offset = OFFSET_INT;
    end else if (w_sel_refill && !cp0_exl) begin
      w_offset = OFFSET_REFILL;
    end else begin
      w_offset = OFFSET_GENERAL;
    end
    w_target = w_sel_eret ? cp0_epc : (w_base + w_offset);
  end

  assign w_active = resetn && (r_state == IDLE) && w_hit;

  // Same-cycle event outputs; nothing commits while reset or redirecting.
  always_comb begin
    if (!resetn || (r_state == REDIRECT)) begin
      commit_mask = '0;
    end else if (w_hit) begin
      commit_mask = w_keep;
    end else begin
      commit_mask = lane_valid;
    end
  end

  assign flush           = w_active;
  assign stall           = resetn && (r_state == REDIRECT);
  assign exc_we          = w_active && w_sel_exc;
  assign eret_we         = w_active && w_sel_eret;
  assign exc_code        = w_sel_code;
  assign exc_epc         = w_sel_bd ? (w_sel_pc - 32'd4) : w_sel_pc;
  assign exc_bd          = w_sel_bd;
  assign exc_badvaddr_we = w_active && w_sel_badv_we;
  assign exc_badvaddr    = w_sel_badv;
  assign redirect_valid  = r_redirect_valid;
  assign redirect_pc     = r_redirect_pc;

  // Redirect FSM: capture the target on an event, hold until fetch accepts.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state          <= IDLE;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_redirect_pc    <= w_target;
            r_redirect_valid <= 1'b1;
            r_state          <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            r_redirect_valid <= 1'b0;
            r_state          <= IDLE;
          end
        end
        default: begin
          r_redirect_valid <= 1'b0;
          r_state          <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
